mtm_alu_deserializer: RTL and testbench
=======================================

// Module: mtm_alu_deserializer
// PURPOSE
//   Serial receive front end of mtm_Alu. Samples sin once per clk, frames 11-bit
//   packets, assembles B, A and CTL, and checks frame count, CRC4 and opcode.
//   Delivers operands to the ALU core as a one-cycle strobe, or raises an error strobe.
//   Sits between the sin pin and the ALU core.
// PARAMETERS
//   TIMEOUT_CYCLES  1000  idle clks allowed between frames of one packet (RX_TIMEOUT_EN only)
// PORTS
//   clk         in   1   system clock, all logic on posedge
//   rst_n       in   1   asynchronous active-low reset
//   sin         in   1   serial input, idle high, 1 bit per clk
//   a_out       out  32  operand A
//   b_out       out  32  operand B
//   op_out      out  3   opcode from CTL[6:4]
//   data_valid  out  1   1-clk strobe: a_out/b_out/op_out valid
//   err_flags   out  3   {ERR_DATA, ERR_CRC, ERR_OP}, one-hot when err_valid
//   err_valid   out  1   1-clk strobe: packet rejected, err_flags valid
//   busy        out  1   high from first start bit until packet closes
// BEHAVIOUR
// - Clock and reset: one clock; reset is asynchronous and active-low (clk, rst_n).
// - Reset values: a_out=0, b_out=0, op_out=0, data_valid=0, err_flags=0, err_valid=0, busy=0.
//   Reset also clears all counters.
// - Frame format: 11 bits, sampled on consecutive posedges.
//   Bit order: start(0), type(0=DATA, 1=CTL), d[7]..d[0], stop(1).
// - Frame sync:
//   - A start bit is sin==0 in state IDLE.
//   - After reset, no start is accepted until sin has been sampled 1 at least once.
// - Frame FSM: IDLE -> TYPE -> DATA (8 bits) -> STOP -> IDLE.
//   - stop==0 is a framing error. The packet is marked bad and reported as ERR_DATA at the next CTL.
//   - The receiver returns to IDLE and waits for sin==1 before the next start.
// - Packet assembly:
//   - DATA frames fill a shift register, first frame into B[31:24].
//   - Frames 1-4 form B (MSB first); frames 5-8 form A.
//   - The data-frame counter saturates at 9 (9 means more than 8).
// - CTL frame closes the packet. CTL = {0, OP[2:0], CRC[3:0]}.
// - Checks on a closed packet, in priority order:
//   1. count != 8 or framing error -> err_flags=3'b100.
//   2. CRC4 (poly x^4+x+1, init 0, serial MSB first over {B,A,1'b1,OP}) != CTL[3:0]
//      -> err_flags=3'b010.
//   3. OP not in {000 AND, 001 OR, 100 ADD, 101 SUB} -> err_flags=3'b001.
//   4. Otherwise: data_valid=1, a_out/b_out/op_out updated.
// - Latency: data_valid or err_valid asserts on the clk after the CTL stop bit is sampled.
//   The strobe lasts exactly 1 clk.
// - Output holding:
//   - a_out, b_out and op_out hold until the next good packet.
//   - On an error they are not updated.
//   - err_flags holds until the next packet closes.
// - After packet close: counter and framing error clear, busy drops with the strobe.
// - No backpressure. The core must accept a strobe in the cycle it occurs.
//   Minimum spacing between strobes is 99 clks (9 frames of 11 bits).
// - CRC computation: either iterative per bit or combinational at close.
//   In both cases the result must be ready in the close cycle.
// CONFIGURATION
//   RX_TIMEOUT_EN defined:
//   - The idle counter runs while busy and between frames, and resets at each start bit.
//   - When it reaches TIMEOUT_CYCLES, the packet is discarded silently: no strobe,
//     counters cleared, busy=0.
//   RX_TIMEOUT_EN undefined:
//   - No counter. A partial packet waits indefinitely for further frames.
// TESTING
// 1. B=7, A=3, OP=100, correct CRC -> data_valid 1 clk; a_out=3, b_out=7, op_out=100, err_valid=0.
// 2. DATA 0x55, DATA 0x0F, CTL 0x50 -> err_valid 1 clk, err_flags=100, data_valid=0.
// 3. B=7, A=3, OP=100, CTL[3:0]= ~correct CRC -> err_flags=010; a_out/b_out keep prior values.
// 4. B=A=0, OP=010, correct CRC -> err_flags=001.
// 5. rst_n low during 5th DATA frame, then B=0xFFFFFFFF, A=0, OP=000 with correct CRC
//    -> outputs 0 during reset, then data_valid with a_out=0, b_out=0xFFFFFFFF.
// 6. RX_TIMEOUT_EN, TIMEOUT_CYCLES=1000: 3 DATA frames, 1200 clks idle, then a full valid packet
//    -> no strobe for the partial packet; valid packet accepted normally.

Source files
------------

// File: rtl/mtm_alu_deserializer.sv
// Serial receive front end of mtm_Alu: frames 11-bit packets from sin, assembles B/A/CTL,
// checks frame count, CRC4 and opcode. Optional inter-frame timeout under `RX_TIMEOUT_EN.
module mtm_alu_deserializer
`ifdef RX_TIMEOUT_EN
  #(parameter int unsigned TIMEOUT_CYCLES = 1000)
`endif
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        sin,
  output logic [31:0] a_out,
  output logic [31:0] b_out,
  output logic [2:0]  op_out,
  output logic        data_valid,
  output logic [2:0]  err_flags,
  output logic        err_valid,
  output logic        busy
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_TYPE = 2'd1;
  localparam logic [1:0] S_DATA = 2'd2;
  localparam logic [1:0] S_STOP = 2'd3;

  localparam logic [2:0] ERR_DATA = 3'b100;
  localparam logic [2:0] ERR_CRC  = 3'b010;
  localparam logic [2:0] ERR_OP   = 3'b001;

  localparam logic [3:0] FRAMES_PER_PACKET = 4'd8;
  localparam logic [3:0] FRAMES_SATURATED  = 4'd9;

  logic [1:0]  state_q,       state_d;
  logic        armed_q,       armed_d;
  logic        type_q,        type_d;
  logic [2:0]  bit_cnt_q,     bit_cnt_d;
  logic [7:0]  byte_q,        byte_d;
  logic [63:0] shift_q,       shift_d;
  logic [3:0]  frame_cnt_q,   frame_cnt_d;
  logic        frame_err_q,   frame_err_d;
  logic        busy_q,        busy_d;
  logic [31:0] a_q,           a_d;
  logic [31:0] b_q,           b_d;
  logic [2:0]  op_q,          op_d;
  logic        data_valid_q,  data_valid_d;
  logic [2:0]  err_flags_q,   err_flags_d;
  logic        err_valid_q,   err_valid_d;
`ifdef RX_TIMEOUT_EN
  logic [31:0] idle_cnt_q,    idle_cnt_d;
`endif

  // CRC4, poly x^4+x+1, init 0, message shifted in MSB first.
  function automatic logic [3:0] crc4(input logic [67:0] msg);
    logic [3:0] c;
    logic       fb;
    c = 4'h0;
    for (int i = 67; i >= 0; i--) begin
      fb = c[3] ^ msg[i];
      c  = {c[2:0], 1'b0} ^ {2'b00, fb, fb};
    end
    return c;
  endfunction

  function automatic logic op_legal(input logic [2:0] op);
    case (op)
      3'b000, 3'b001, 3'b100, 3'b101: return 1'b1;
      default:                        return 1'b0;
    endcase
  endfunction

  logic        start_bit;
  logic [2:0]  ctl_op;
  logic [3:0]  ctl_crc;
  logic [3:0]  calc_crc;

  assign start_bit = (state_q == S_IDLE) && armed_q && !sin;
  assign ctl_op    = byte_q[6:4];
  assign ctl_crc   = byte_q[3:0];
  assign calc_crc  = crc4({shift_q, 1'b1, ctl_op});

  always_comb begin
    // NOTE: every next-state variable takes its current value first, so no path can infer a latch.
    state_d      = state_q;
    armed_d      = armed_q;
    type_d       = type_q;
    bit_cnt_d    = bit_cnt_q;
    byte_d       = byte_q;
    shift_d      = shift_q;
    frame_cnt_d  = frame_cnt_q;
    frame_err_d  = frame_err_q;
    busy_d       = busy_q;
    a_d          = a_q;
    b_d          = b_q;
    op_d         = op_q;
    data_valid_d = 1'b0;
    err_flags_d  = err_flags_q;
    err_valid_d  = 1'b0;

    if (sin) armed_d = 1'b1;

    case (state_q)
      S_IDLE: begin
        if (start_bit) begin
          state_d = S_TYPE;
          busy_d  = 1'b1;
        end
      end
      S_TYPE: begin
        type_d    = sin;
        bit_cnt_d = 3'd0;
        state_d   = S_DATA;
      end
      S_DATA: begin
        byte_d    = {byte_q[6:0], sin};
        bit_cnt_d = bit_cnt_q + 3'd1;
        if (bit_cnt_q == 3'd7) state_d = S_STOP;
      end
      default: begin
        state_d = S_IDLE;
        // A missing stop bit forces a fresh idle-high before the next start is trusted.
        if (!sin) armed_d = 1'b0;
        if (!type_q) begin
          if (!sin) begin
            frame_err_d = 1'b1;
          end else begin
            shift_d = {shift_q[55:0], byte_q};
            if (frame_cnt_q != FRAMES_SATURATED) frame_cnt_d = frame_cnt_q + 4'd1;
          end
        end else begin
          busy_d      = 1'b0;
          frame_cnt_d = 4'd0;
          frame_err_d = 1'b0;
          if ((frame_cnt_q != FRAMES_PER_PACKET) || frame_err_q || !sin) begin
            err_flags_d = ERR_DATA;
            err_valid_d = 1'b1;
          end else if (calc_crc != ctl_crc) begin
            err_flags_d = ERR_CRC;
            err_valid_d = 1'b1;
          end else if (!op_legal(ctl_op)) begin
            err_flags_d = ERR_OP;
            err_valid_d = 1'b1;
          end else begin
            err_flags_d  = 3'b000;
            data_valid_d = 1'b1;
            b_d          = shift_q[63:32];
            a_d          = shift_q[31:0];
            op_d         = ctl_op;
          end
        end
      end
    endcase

`ifdef RX_TIMEOUT_EN
    // Idle time is only measured between frames of a packet already in progress.
    idle_cnt_d = 32'd0;
    if (busy_q && (state_q == S_IDLE) && !start_bit) begin
      if (idle_cnt_q == TIMEOUT_CYCLES - 1) begin
        busy_d      = 1'b0;
        frame_cnt_d = 4'd0;
        frame_err_d = 1'b0;
      end else begin
        idle_cnt_d = idle_cnt_q + 32'd1;
      end
    end
`endif
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      armed_q      <= 1'b0;
      type_q       <= 1'b0;
      bit_cnt_q    <= 3'd0;
      byte_q       <= 8'h00;
      shift_q      <= 64'h0;
      frame_cnt_q  <= 4'd0;
      frame_err_q  <= 1'b0;
      busy_q       <= 1'b0;
      a_q          <= 32'h0;
      b_q          <= 32'h0;
      op_q         <= 3'b000;
      data_valid_q <= 1'b0;
      err_flags_q  <= 3'b000;
      err_valid_q  <= 1'b0;
`ifdef RX_TIMEOUT_EN
      idle_cnt_q   <= 32'd0;
`endif
    end else begin
      state_q      <= state_d;
      armed_q      <= armed_d;
      type_q       <= type_d;
      bit_cnt_q    <= bit_cnt_d;
      byte_q       <= byte_d;
      shift_q      <= shift_d;
      frame_cnt_q  <= frame_cnt_d;
      frame_err_q  <= frame_err_d;
      busy_q       <= busy_d;
      a_q          <= a_d;
      b_q          <= b_d;
      op_q         <= op_d;
      data_valid_q <= data_valid_d;
      err_flags_q  <= err_flags_d;
      err_valid_q  <= err_valid_d;
`ifdef RX_TIMEOUT_EN
      idle_cnt_q   <= idle_cnt_d;
`endif
    end
  end

  assign a_out      = a_q;
  assign b_out      = b_q;
  assign op_out     = op_q;
  assign data_valid = data_valid_q;
  assign err_flags  = err_flags_q;
  assign err_valid  = err_valid_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_mtm_alu_deserializer.sv
// Scoreboard bench for mtm_alu_deserializer: packet-level reference model pushes expected
// strobes; an independent monitor pops and compares whenever the DUT strobes.
module tb_mtm_alu_deserializer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        sin = 1'b1;
  logic [31:0] a_out, b_out;
  logic [2:0]  op_out, err_flags;
  logic        data_valid, err_valid, busy;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic        dv;
    logic [2:0]  flags;
    logic [31:0] a;
    logic [31:0] b;
    logic [2:0]  op;
  } exp_t;

  exp_t       exp_q[$];
  logic [7:0] pend[$];
  logic       model_ferr = 1'b0;
  logic [31:0] last_a = '0, last_b = '0;
  logic [2:0]  last_op = '0;

  mtm_alu_deserializer dut (
    .clk(clk), .rst_n(rst_n), .sin(sin),
    .a_out(a_out), .b_out(b_out), .op_out(op_out),
    .data_valid(data_valid), .err_flags(err_flags),
    .err_valid(err_valid), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  // Reference CRC: remainder of M(x)*x^4 divided by x^4+x+1.
  function automatic logic [3:0] ref_crc(input logic [31:0] b, input logic [31:0] a,
                                         input logic [2:0] op);
    logic [71:0] m;
    m = {b, a, 1'b1, op, 4'b0000};
    for (int i = 71; i >= 4; i--)
      if (m[i]) m[i-:5] = m[i-:5] ^ 5'b10011;
    return m[3:0];
  endfunction

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1 sin = 1'b1;
    end
  endtask

  task automatic send_frame(input logic typ, input logic [7:0] d, input logic stop);
    logic [10:0] bits;
    bits = {1'b0, typ, d, stop};
    for (int i = 10; i >= 0; i--) begin
      @(posedge clk); #1 sin = bits[i];
    end
    @(posedge clk); #1 sin = 1'b1;
  endtask

  task automatic send_data(input logic [7:0] d, input logic stop_ok);
    if (stop_ok) pend.push_back(d);
    else         model_ferr = 1'b1;
    send_frame(1'b0, d, stop_ok);
    if (!stop_ok) idle(1);
  endtask

  task automatic send_ctl(input logic [2:0] op, input logic [3:0] crc);
    exp_t        e;
    logic [31:0] b, a;
    e.dv = 1'b0; e.a = last_a; e.b = last_b; e.op = last_op;
    if (pend.size() != 8 || model_ferr) begin
      e.flags = 3'b100;
    end else begin
      b = {pend[0], pend[1], pend[2], pend[3]};
      a = {pend[4], pend[5], pend[6], pend[7]};
      if (ref_crc(b, a, op) != crc)               e.flags = 3'b010;
      else if (!(op inside {3'd0, 3'd1, 3'd4, 3'd5})) e.flags = 3'b001;
      else begin
        e.flags = 3'b000; e.dv = 1'b1;
        e.a = a; e.b = b; e.op = op;
        last_a = a; last_b = b; last_op = op;
      end
    end
    pend.delete();
    model_ferr = 1'b0;
    exp_q.push_back(e);
    send_frame(1'b1, {1'b0, op, crc}, 1'b1);
    repeat (3) @(negedge clk);
    check("strobe_seen", 64'(exp_q.size()), 64'd0);
    check("busy_after_close", 64'(busy), 64'd0);
    exp_q.delete();
  endtask

  task automatic send_packet(input logic [31:0] b, input logic [31:0] a,
                             input logic [2:0] op, input logic crc_ok);
    logic [3:0] c;
    idle(2);
    for (int i = 3; i >= 0; i--) send_data(b[i*8 +: 8], 1'b1);
    for (int i = 3; i >= 0; i--) send_data(a[i*8 +: 8], 1'b1);
    c = ref_crc(b, a, op);
    send_ctl(op, crc_ok ? c : ~c);
  endtask

  // Monitor: every strobe must match the oldest expectation.
  always @(negedge clk) begin
    if (rst_n && (data_valid || err_valid)) begin
      if (exp_q.size() == 0) begin
        check("unexpected_strobe", {62'd0, data_valid, err_valid}, 64'd0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("data_valid", 64'(data_valid), 64'(e.dv));
        check("err_valid",  64'(err_valid),  64'(!e.dv));
        check("err_flags",  64'(err_flags),  64'(e.flags));
        check("a_out",      64'(a_out),      64'(e.a));
        check("b_out",      64'(b_out),      64'(e.b));
        check("op_out",     64'(op_out),     64'(e.op));
      end
    end
  end

  task automatic check_reset_outputs(input string tag);
    check({tag, "_a"},    64'(a_out), 64'd0);
    check({tag, "_b"},    64'(b_out), 64'd0);
    check({tag, "_op"},   64'(op_out), 64'd0);
    check({tag, "_dv"},   64'(data_valid), 64'd0);
    check({tag, "_ef"},   64'(err_flags), 64'd0);
    check({tag, "_ev"},   64'(err_valid), 64'd0);
    check({tag, "_busy"}, 64'(busy), 64'd0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] c;
    sin = 1'b1;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #2 check_reset_outputs("reset");
    @(posedge clk); #1 rst_n = 1'b1;

    // Good packet, busy during reception.
    idle(2);
    send_data(8'h00, 1'b1);
    @(negedge clk) check("busy_in_packet", 64'(busy), 64'd1);
    send_data(8'h00, 1'b1); send_data(8'h00, 1'b1); send_data(8'h07, 1'b1);
    for (int i = 0; i < 3; i++) send_data(8'h00, 1'b1);
    send_data(8'h03, 1'b1);
    send_ctl(3'b100, ref_crc(32'd7, 32'd3, 3'b100));

    // Short packet, then bad CRC, then illegal opcode.
    idle(2);
    send_data(8'h55, 1'b1); send_data(8'h0F, 1'b1);
    send_ctl(3'b101, 4'h0);
    send_packet(32'd7, 32'd3, 3'b100, 1'b0);
    send_packet(32'd0, 32'd0, 3'b010, 1'b1);

    // Framing error in frame 3, and a 9-frame packet.
    idle(2);
    for (int i = 0; i < 8; i++) send_data(8'(i * 17), i != 2);
    send_ctl(3'b000, 4'h0);
    idle(2);
    for (int i = 0; i < 9; i++) send_data(8'(i + 1), 1'b1);
    send_ctl(3'b001, 4'h5);

    // Randomized packets over all opcodes with occasional CRC corruption.
    for (int n = 0; n < 24; n++)
      send_packet($urandom, $urandom, 3'($urandom_range(0, 7)), $urandom_range(0, 3) != 0);

    // Reset in the middle of the 5th DATA frame.
    idle(2);
    for (int i = 0; i < 4; i++) send_data(8'hA5, 1'b1);
    @(posedge clk); #1 sin = 1'b0;
    @(posedge clk); #1 sin = 1'b0;
    @(posedge clk); #1 sin = 1'b1;
    @(posedge clk); #1 sin = 1'b0;
    #3 rst_n = 1'b0;
    sin = 1'b1;
    pend.delete(); model_ferr = 1'b0;
    last_a = '0; last_b = '0; last_op = '0;
    #2 check_reset_outputs("midreset");
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    send_packet(32'hFFFF_FFFF, 32'h0, 3'b000, 1'b1);

    // Partial packet followed by a long idle gap, then a full packet.
    idle(2);
    for (int i = 0; i < 3; i++) send_data(8'h3C, 1'b1);
    idle(1200);
`ifdef RX_TIMEOUT_EN
    @(negedge clk) check("busy_after_timeout", 64'(busy), 64'd0);
    pend.delete();
`else
    @(negedge clk) check("busy_waiting", 64'(busy), 64'd1);
`endif
    send_packet(32'h1234_5678, 32'h9ABC_DEF0, 3'b101, 1'b1);

    // Illegal opcode with correct CRC after a good packet keeps prior outputs.
    c = ref_crc(32'h0BAD_F00D, 32'h1, 3'b111);
    idle(2);
    for (int i = 3; i >= 0; i--) send_data(8'(32'h0BAD_F00D >> (i * 8)), 1'b1);
    for (int i = 3; i >= 0; i--) send_data(8'(32'h1 >> (i * 8)), 1'b1);
    send_ctl(3'b111, c);

    idle(5);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
